// File: rtl/alu_preprocess_pipe.sv
// Operand preprocessor for the ALU datapath.
// Decodes (A, B, Op) into the conditioned adder operands AMod/BMod and the
// carry-in Cin, and queues each result in a 2-entry output buffer so that
// back-pressure from the adder never drops an operation. A held copy of B
// lets later "add held" operations reuse an earlier operand. A sticky flag
// records any accepted illegal opcode.
//
// The buffer is a head/tail pair. The head register always drives the
// outputs, so when the buffer drains it keeps showing the last emitted entry.
module alu_preprocess_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] AMod,
  output logic [WIDTH-1:0] BMod,
  output logic             Cin,
  output logic [2:0]       OpOut,
  output logic             err
);

  typedef struct packed {
    logic [2:0]       op;
    logic             cin;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } entry_t;

  localparam logic [2:0] OP_PASS  = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_NEG   = 3'b100;
  localparam logic [2:0] OP_ADDH  = 3'b101;
  localparam logic [2:0] OP_COMPL = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  logic [1:0]       r_count;
  entry_t           r_head;
  entry_t           r_tail;
  logic [WIDTH-1:0] r_bhold;
  logic             r_err;

  entry_t           w_dec;
  logic             w_load_bhold;
  logic             w_illegal;
  logic             w_accept;
  logic             w_emit;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_accept  = in_valid & in_ready;
  assign w_emit    = out_valid & out_ready;

  assign AMod  = r_head.a;
  assign BMod  = r_head.b;
  assign Cin   = r_head.cin;
  assign OpOut = r_head.op;
  assign err   = r_err;

  // Input-side opcode decode into the entry that would be buffered this cycle.
  always_comb begin
    w_dec        = '0;
    w_dec.a      = A;
    w_dec.op     = Op;
    w_load_bhold = 1'b0;
    w_illegal    = 1'b0;
    case (Op)
      OP_PASS: ;
      OP_INC: w_dec.cin = 1'b1;
      OP_ADD: begin
        w_dec.b      = B;
        w_load_bhold = 1'b1;
      end
      OP_SUB: begin
        w_dec.b      = ~B;
        w_dec.cin    = 1'b1;
        w_load_bhold = 1'b1;
      end
      OP_NEG: begin
        w_dec.a   = ~A;
        w_dec.cin = 1'b1;
      end
      OP_ADDH: w_dec.b = r_bhold;
      OP_COMPL: w_dec.a = ~A;
      OP_ILL: begin
        w_dec.a   = '0;
        w_illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // Buffer occupancy and head/tail entry movement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_accept, w_emit})
        2'b10: begin
          if (r_count == 2'd0) r_head <= w_dec;
          else                 r_tail <= w_dec;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        // Both at once only happens at count 1: the new entry replaces the head.
        2'b11: r_head <= w_dec;
        default: ;
      endcase
    end
  end

  // Held operand for "add held" and the sticky illegal-op flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bhold <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      if (w_load_bhold) r_bhold <= B;
      if (w_illegal)    r_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_preprocess_pipe.sv
// Scoreboard bench for alu_preprocess_pipe (WIDTH=4). The driver pushes the
// hand-computed expected entry when an operation is accepted; an independent
// monitor pops and compares whenever the DUT emits.
module tb_alu_preprocess_pipe;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [2:0] op;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ec;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [2:0] Op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] AMod;
  logic [3:0] BMod;
  logic       Cin;
  logic [2:0] OpOut;
  logic       err;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;

  alu_preprocess_pipe #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op),
    .out_valid(out_valid), .out_ready(out_ready),
    .AMod(AMod), .BMod(BMod), .Cin(Cin), .OpOut(OpOut),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each emit (out_valid & out_ready before the edge) is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {out_valid, 31'd0}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_entry", {20'd0, AMod, BMod, Cin, OpOut}, {20'd0, e});
        end
      end
    end
  end

  // Offer one operation until accepted (bounded); record its expected entry on accept.
  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] ea, input logic [3:0] eb, input logic ec);
    bit done = 1'b0;
    A = a; B = b; Op = op; in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        sb.push_back({ea, eb, ec, op});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask

  vec_t sweep[6];

  initial begin
    sweep[0] = '{3'b000, 4'b0101, 4'b0011, 4'b0101, 4'b0000, 1'b0};
    sweep[1] = '{3'b001, 4'b0101, 4'b0011, 4'b0101, 4'b0000, 1'b1};
    sweep[2] = '{3'b010, 4'b0101, 4'b0011, 4'b0101, 4'b0011, 1'b0};
    sweep[3] = '{3'b011, 4'b0101, 4'b0011, 4'b0101, 4'b1100, 1'b1};
    sweep[4] = '{3'b100, 4'b0101, 4'b0011, 4'b1010, 4'b0000, 1'b1};
    sweep[5] = '{3'b110, 4'b0101, 4'b0011, 4'b1010, 4'b0000, 1'b0};

    // Reset and idle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_err",       {31'd0, err},       32'd0);
    check("rst_amod_bmod", {24'd0, AMod, BMod}, 32'd0);
    check("rst_cin_opout", {28'd0, Cin, OpOut}, 32'd0);

    // Decode sweep, each entry visible one edge after accept
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(sweep[i].op, sweep[i].a, sweep[i].b, sweep[i].ea, sweep[i].eb, sweep[i].ec);
      check("latency_valid", {31'd0, out_valid}, 32'd1);
      check("latency_opout", {29'd0, OpOut}, {29'd0, sweep[i].op});
    end
    drain();

    // Held B reuse
    push(3'b010, 4'b0010, 4'b0111, 4'b0010, 4'b0111, 1'b0);
    push(3'b101, 4'b0001, 4'b1111, 4'b0001, 4'b0111, 1'b0);
    push(3'b011, 4'b0100, 4'b0010, 4'b0100, 4'b1101, 1'b1);
    push(3'b101, 4'b0011, 4'b0000, 4'b0011, 4'b0010, 1'b0);
    drain();

    // Back-pressure: two fill the buffer, the third waits until a slot frees
    out_ready = 1'b0;
    push(3'b000, 4'b0001, 4'b1001, 4'b0001, 4'b0000, 1'b0);
    push(3'b001, 4'b0010, 4'b1001, 4'b0010, 4'b0000, 1'b1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    fork
      push(3'b100, 4'b0011, 4'b1001, 4'b1100, 4'b0000, 1'b1);
      begin
        @(negedge clk);
        check("full_held_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Streaming at count 1
    push(3'b001, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      push(3'b001, 4'(i), 4'b0000, 4'(i), 4'b0000, 1'b1);
      check("stream_count1", {30'd0, out_valid, in_ready}, 32'd3);
    end
    drain();

    // Illegal op and sticky err
    push(3'b111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    check("err_set", {31'd0, err}, 32'd1);
    push(3'b010, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0);
    push(3'b000, 4'b0110, 4'b0001, 4'b0110, 4'b0000, 1'b0);
    drain();
    check("err_sticky", {31'd0, err}, 32'd1);
    check("empty_holds_last", {24'd0, AMod, BMod}, {24'd0, 4'b0110, 4'b0000});
    repeat (2) @(posedge clk);
    #1;
    check("empty_ignores_ready", {31'd0, out_valid}, 32'd0);

    // Reset flush with a full buffer
    out_ready = 1'b0;
    push(3'b001, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 1'b1);
    push(3'b100, 4'b1010, 4'b0000, 4'b0101, 4'b0000, 1'b1);
    check("flush_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_err", {31'd0, err}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_amod", {28'd0, AMod}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("flush_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
